// File: rtl/demux_stream_nch.sv
// -----------------------------------------------------------------------------
// demux_stream_nch
//
// Registered 1-to-NUM_CH word demultiplexer with a valid/ready handshake on
// the input side and per-channel valid/ready on the output side. One word is
// held at a time. A pending mask records which channels are still owed that
// word. A new word is accepted as soon as the last owed channel drains,
// including in the same cycle, so throughput is one word per clock.
//
// Parameters
//   WIDTH   data word width in bits (>= 1)
//   NUM_CH  number of output channels (2..16, any value)
//   SELW    select width, derived from NUM_CH (not overridable)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   source presents a word
//   in_ready   block can take a word this cycle
//   in_data    word to route
//   in_sel     destination channel index
//   in_bcast   (only with DEMUX_STREAM_BCAST_EN) deliver the word to every channel
//   out_valid  per-channel valid, bit k = channel k
//   out_ready  per-channel consumer ready
//   out_data   flattened outputs, channel k at [k*WIDTH +: WIDTH]; idle channels read 0
//   sel_err    one-cycle pulse after a word with in_sel >= NUM_CH was consumed
//
// Optional feature
//   Define DEMUX_STREAM_BCAST_EN to add the in_bcast input. A broadcast word
//   is owed to all channels. Each channel drains on its own ready, and the
//   input reopens only after the last channel has taken the word.
// -----------------------------------------------------------------------------
module demux_stream_nch #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SELW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SELW-1:0]         in_sel,
`ifdef DEMUX_STREAM_BCAST_EN
  input  logic                    in_bcast,
`endif
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    sel_err
);

  // Two-state view of the holding register: EMPTY when no channel is owed
  // the held word, FULL otherwise.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // The select is compared one bit wider than its own width. That keeps the
  // range test exact even when NUM_CH is a power of two.
  localparam logic [SELW:0] CH_LIMIT = (SELW+1)'(NUM_CH);

  logic [0:0]        state_reg,   state_next;
  logic [NUM_CH-1:0] pend_reg,    pend_next;
  logic [WIDTH-1:0]  data_reg,    data_next;
  logic              sel_err_reg, sel_err_next;

  logic [NUM_CH-1:0] done_mask;
  logic [NUM_CH-1:0] remain_mask;
  logic [NUM_CH-1:0] sel_onehot;
  logic              sel_in_range;
  logic              accept;
  logic              bcast;

`ifdef DEMUX_STREAM_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Select decode
  // ---------------------------------------------------------------------------
  assign sel_in_range = ({1'b0, in_sel} < CH_LIMIT);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_decode
      assign sel_onehot[gi] = (in_sel == SELW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Drain and handshake
  // ---------------------------------------------------------------------------
  // A channel is served when it is owed the word and its consumer is ready.
  // out_ready on an idle channel falls out of the AND and has no effect.
  assign done_mask   = pend_reg & out_ready;
  assign remain_mask = pend_reg & ~done_mask;

  // The input opens when nothing will still be owed after this edge. That
  // allows a word to be taken in the same cycle the last channel drains.
  assign in_ready = (state_reg == ST_EMPTY) || (remain_mask == '0);
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_next    = remain_mask;
    data_next    = data_reg;
    sel_err_next = 1'b0;

    if (accept) begin
      if (bcast) begin
        pend_next = '1;
        data_next = in_data;
      end else if (sel_in_range) begin
        // The new word's mask replaces the old one completely. Any channel
        // still owed is already known to be draining on this edge.
        pend_next = sel_onehot;
        data_next = in_data;
      end else begin
        // An unroutable word is consumed and dropped. The previous data
        // stays in the register but is invisible, because pend is zero.
        pend_next    = '0;
        sel_err_next = 1'b1;
      end
    end

    state_next = (pend_next != '0) ? ST_FULL : ST_EMPTY;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_EMPTY;
      pend_reg    <= '0;
      data_reg    <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      data_reg    <= data_next;
      sel_err_reg <= sel_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: every output comes from a register, with no path from in_data
  // ---------------------------------------------------------------------------
  assign out_valid = pend_reg;
  assign sel_err   = sel_err_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
      // Idle channels read zero, matching the combinational demux this replaces.
      assign out_data[gi*WIDTH +: WIDTH] = pend_reg[gi] ? data_reg : '0;
    end
  endgenerate

endmodule

// File: tb/tb_demux_stream_nch.sv
// -----------------------------------------------------------------------------
// tb_demux_stream_nch
//
// Bench for demux_stream_nch. It drives two instances:
//   u_dut4  WIDTH=8, NUM_CH=4  reset, routing, backpressure, reset mid-transfer,
//                              broadcast (when enabled) and a random phase
//   u_dut3  WIDTH=8, NUM_CH=3  out-of-range select handling
// Expected values come from directed constants, plus a per-channel "owed"
// model for the random phase.
// -----------------------------------------------------------------------------
module tb_demux_stream_nch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Four-channel instance
  logic        in_valid4;
  logic        in_ready4;
  logic [7:0]  in_data4;
  logic [1:0]  in_sel4;
  logic        in_bcast4;
  logic [3:0]  out_valid4;
  logic [3:0]  out_ready4;
  logic [31:0] out_data4;
  logic        sel_err4;

  // Three-channel instance
  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic        in_bcast3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [23:0] out_data3;
  logic        sel_err3;

  demux_stream_nch #(.WIDTH(8), .NUM_CH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .in_sel    (in_sel4),
`ifdef DEMUX_STREAM_BCAST_EN
    .in_bcast  (in_bcast4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .sel_err   (sel_err4)
  );

  demux_stream_nch #(.WIDTH(8), .NUM_CH(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
`ifdef DEMUX_STREAM_BCAST_EN
    .in_bcast  (in_bcast3),
`endif
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .sel_err   (sel_err3)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the random phase. Each channel is simply "owed" the
  // held word or not. It is delivered on the first cycle that channel is ready.
  bit         owed [4];
  logic [7:0] held;

  initial begin
    logic [31:0] exp_data;
    logic [3:0]  exp_valid;
    logic        exp_rdy;
    logic        any_left;
    logic [3:0]  k_mask;
    bit          src_v;
    bit          src_bc;
    logic [7:0]  src_d;
    logic [1:0]  src_s;
    bit          hold_src;
    int          txn;

    // ---------------- reset ----------------
    rst = 1'b1;
    in_valid4 = 1'b1; in_data4 = 8'hA5; in_sel4 = 2'd0; in_bcast4 = 1'b0; out_ready4 = 4'h0;
    in_valid3 = 1'b0; in_data3 = 8'h00; in_sel3 = 2'd0; in_bcast3 = 1'b0; out_ready3 = 3'h0;
    tick();
    tick();
    check("reset_out_valid", 64'(out_valid4), 64'h0);
    check("reset_out_data",  64'(out_data4),  64'h0);
    check("reset_in_ready",  64'(in_ready4),  64'h1);
    check("reset_sel_err",   64'(sel_err4),   64'h0);
    check("reset3_out_valid", 64'(out_valid3), 64'h0);
    rst = 1'b0;
    in_valid4 = 1'b0;
    tick();
    $display("txn reset: outputs idle after reset");

    // ---------------- routing sweep ----------------
    out_ready4 = 4'hF;
    for (int s = 0; s < 4; s++) begin
      in_valid4 = 1'b1; in_data4 = 8'h3C; in_sel4 = 2'(s);
      #1;
      check($sformatf("route_in_ready_%0d", s), 64'(in_ready4), 64'h1);
      tick();
      check($sformatf("route_valid_%0d", s), 64'(out_valid4), 64'(4'b0001 << s));
      check($sformatf("route_data_%0d", s),  64'(out_data4),  64'(32'h3C << (8*s)));
      $display("txn route: data=3c sel=%0d", s);
    end
    in_valid4 = 1'b0;
    tick();
    check("route_drained", 64'(out_valid4), 64'h0);

    // ---------------- backpressure ----------------
    in_valid4 = 1'b1; in_data4 = 8'h5A; in_sel4 = 2'd2; out_ready4 = 4'b1011;
    tick();
    in_data4 = 8'h11; in_sel4 = 2'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", c),  64'(in_ready4),  64'h0);
      check($sformatf("bp_out_valid_%0d", c), 64'(out_valid4), 64'h4);
      check($sformatf("bp_out_data_%0d", c),  64'(out_data4),  64'h005A0000);
      tick();
    end
    out_ready4 = 4'hF;
    #1;
    check("bp_drain_in_ready", 64'(in_ready4), 64'h1);
    tick();
    in_valid4 = 1'b0;
    check("bp_next_valid", 64'(out_valid4), 64'h1);
    check("bp_next_data",  64'(out_data4),  64'h11);
    tick();
    check("bp_idle", 64'(out_valid4), 64'h0);
    $display("txn backpressure: 5a held 3 cycles then 11 accepted on drain");

    // ---------------- out-of-range select (NUM_CH=3) ----------------
    out_ready3 = 3'b111;
    in_valid3 = 1'b1; in_data3 = 8'h9C; in_sel3 = 2'd2;
    tick();
    check("nc3_valid_sel2", 64'(out_valid3), 64'h4);
    check("nc3_data_sel2",  64'(out_data3),  64'h9C0000);
    in_data3 = 8'h77; in_sel3 = 2'b11;
    #1;
    check("oor_in_ready", 64'(in_ready3), 64'h1);
    tick();
    in_valid3 = 1'b0;
    check("oor_sel_err",   64'(sel_err3),   64'h1);
    check("oor_out_valid", 64'(out_valid3), 64'h0);
    check("oor_out_data",  64'(out_data3),  64'h0);
    tick();
    check("oor_sel_err_pulse", 64'(sel_err3), 64'h0);
    $display("txn oor: sel=3 dropped with one-cycle sel_err");

    // ---------------- reset mid-transfer ----------------
    in_valid4 = 1'b1; in_data4 = 8'h42; in_sel4 = 2'd1; out_ready4 = 4'h0;
    tick();
    in_valid4 = 1'b0;
    check("mid_pending", 64'(out_valid4), 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid4), 64'h0);
    check("mid_rst_data",  64'(out_data4),  64'h0);
    check("mid_rst_ready", 64'(in_ready4),  64'h1);
    out_ready4 = 4'hF;
    tick();
    tick();
    check("mid_never_delivered", 64'(out_valid4), 64'h0);
    $display("txn midreset: held word 42 discarded");

`ifdef DEMUX_STREAM_BCAST_EN
    // ---------------- broadcast ----------------
    in_valid4 = 1'b1; in_bcast4 = 1'b1; in_data4 = 8'hFF; in_sel4 = 2'd0; out_ready4 = 4'h0;
    tick();
    in_valid4 = 1'b0; in_bcast4 = 1'b0;
    out_ready4 = 4'b0011;
    #1;
    check("bc_valid_all", 64'(out_valid4), 64'hF);
    check("bc_ready_lo",  64'(in_ready4),  64'h0);
    check("bc_no_err",    64'(sel_err4),   64'h0);
    tick();
    check("bc_valid_hi",  64'(out_valid4), 64'hC);
    check("bc_data_hi",   64'(out_data4),  64'hFFFF0000);
    out_ready4 = 4'b1100;
    #1;
    check("bc_ready_last", 64'(in_ready4), 64'h1);
    tick();
    check("bc_done", 64'(out_valid4), 64'h0);
    $display("txn bcast: ff delivered to all channels");
`endif

    // ---------------- random phase against the model ----------------
    for (int k = 0; k < 4; k++) owed[k] = 1'b0;
    held     = 8'h00;
    hold_src = 1'b0;
    src_v = 1'b0; src_bc = 1'b0; src_d = 8'h00; src_s = 2'd0;
    txn = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold_src) begin
        src_v  = ($urandom_range(0, 3) != 0);
        src_d  = 8'($urandom);
        src_s  = 2'($urandom_range(0, 3));
`ifdef DEMUX_STREAM_BCAST_EN
        src_bc = ($urandom_range(0, 7) == 0);
`else
        src_bc = 1'b0;
`endif
      end
      in_valid4  = src_v;
      in_data4   = src_d;
      in_sel4    = src_s;
      in_bcast4  = src_bc;
      out_ready4 = 4'($urandom);
      #1;

      exp_valid = '0;
      exp_data  = '0;
      any_left  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (owed[k]) begin
          exp_valid[k]        = 1'b1;
          exp_data[k*8 +: 8]  = held;
          if (!out_ready4[k]) any_left = 1'b1;
        end
      end
      exp_rdy = !any_left;

      check($sformatf("rnd_valid_c%0d", cyc), 64'(out_valid4), 64'(exp_valid));
      check($sformatf("rnd_data_c%0d", cyc),  64'(out_data4),  64'(exp_data));
      check($sformatf("rnd_ready_c%0d", cyc), 64'(in_ready4),  64'(exp_rdy));
      check($sformatf("rnd_err_c%0d", cyc),   64'(sel_err4),   64'h0);

      // Model update at the edge
      if (src_v && exp_rdy) begin
        held = src_d;
        k_mask = src_bc ? 4'hF : (4'b0001 << src_s);
        for (int k = 0; k < 4; k++) owed[k] = k_mask[k];
        txn++;
        $display("txn %0d: cyc=%0d data=%h sel=%0d bcast=%0d", txn, cyc, src_d, src_s, src_bc);
        hold_src = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) if (out_ready4[k]) owed[k] = 1'b0;
        hold_src = src_v;
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
